// File: rtl/srio_user_pkg.sv
// -----------------------------------------------------------------------------
// srio_user_pkg
// Shared definitions for the user NWRITE traffic generator:
//   - state_t      : sequencer state encoding
//   - LFSR_TAPS    : feedback taps of x^32 + x^22 + x^2 + x + 1 (Fibonacci form)
//   - LFSR_SEED    : value loaded into the LFSR at the start of a run
//   - calc_beats() : beats needed for a payload of (size+1) bytes
//   - rem_bytes()  : number of valid bytes in the last beat of a packet
//   - lfsr_step()  : one LFSR shift
// -----------------------------------------------------------------------------
package srio_user_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RDY  = 2'd1,
        DATA      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Bits 31, 21, 1 and 0 correspond to the x^32, x^22, x^2 and x terms.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

    // ceil((size+1)/bpb) for a power-of-two bpb reduces to (size >> log2(bpb)) + 1.
    function automatic logic [12:0] calc_beats(input logic [11:0] size, input int bpb_log2);
        return ({1'b0, size} >> bpb_log2) + 13'd1;
    endfunction

    // Bytes carried by the final beat: 1..bpb, never 0.
    function automatic logic [4:0] rem_bytes(input logic [11:0] size, input int bpb_log2);
        logic [11:0] low;
        low = size & ((12'd1 << bpb_log2) - 12'd1);
        return 5'(low) + 5'd1;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [31:0] lfsr_init();
        return LFSR_SEED;
    endfunction

endpackage

// File: rtl/user_pattern_gen.sv
// -----------------------------------------------------------------------------
// user_pattern_gen
// Payload pattern source. Lanes are 32 bits wide and filled MSB-first with
// consecutive pattern values; the pattern advances by one value per lane each
// time a beat is accepted, and restarts when init is pulsed.
//
// Optional feature macro: USER_NWR_GEN_LFSR_EN
//   defined   : mode=1 selects a 32-bit LFSR pattern, mode=0 the word counter
//   undefined : no LFSR logic; mode is ignored and the counter is always used
//
// Ports:
//   clk      in   clock (rising edge)
//   rst      in   synchronous active-high reset
//   init     in   restart the pattern (start of a run)
//   advance  in   beat accepted, step to the next beat's values
//   mode     in   pattern select (0 counter, 1 LFSR)
//   data     out  current beat payload, DATA_W bits
// -----------------------------------------------------------------------------
module user_pattern_gen
    import srio_user_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              advance,
    input  logic              mode,
    output logic [DATA_W-1:0] data
);

    localparam int LANES = DATA_W / 32;

    logic [31:0]       ctr;
    logic [DATA_W-1:0] ctr_data;

    // NOTE: sequential state is written with <= so every register in the design samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr <= '0;
        end else if (init) begin
            ctr <= '0;
        end else if (advance) begin
            ctr <= ctr + 32'(LANES);
        end
    end

    // NOTE: the output gets a default before the loop so no path through this block can infer a latch.
    always_comb begin
        ctr_data = '0;
        for (int k = 0; k < LANES; k++) begin
            ctr_data[DATA_W-1-32*k -: 32] = ctr + 32'(k);
        end
    end

`ifdef USER_NWR_GEN_LFSR_EN
    logic [31:0]       lfsr;
    logic [31:0]       lfsr_walk;
    logic [DATA_W-1:0] lfsr_data;

    // Walk the LFSR once per lane; the value left after the last lane is
    // the first lane of the next beat.
    always_comb begin
        lfsr_walk = lfsr;
        lfsr_data = '0;
        for (int k = 0; k < LANES; k++) begin
            lfsr_data[DATA_W-1-32*k -: 32] = lfsr_walk;
            lfsr_walk = lfsr_step(lfsr_walk);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || init) begin
            lfsr <= lfsr_init();
        end else if (advance) begin
            lfsr <= lfsr_walk;
        end
    end

    assign data = mode ? lfsr_data : ctr_data;
`else
    // Only the counter pattern exists in this build.
    logic unused_mode;
    assign unused_mode = mode;
    assign data        = ctr_data;
`endif

endmodule

// File: rtl/user_nwr_gen.sv
// -----------------------------------------------------------------------------
// user_nwr_gen
// Generates runs of NWRITE packets on an AXI-stream style user interface.
// A run is started by start_in; each packet waits for nwr_ready_in, streams
// ceil((size+1)/(DATA_W/8)) beats and then waits for nwr_done_in. A run ends
// after pkt_num_in packets (0 = continuous) or after the packet in progress
// when abort_in is seen; done_o pulses on return to IDLE.
//
// Optional feature macro: USER_NWR_GEN_LFSR_EN (LFSR payload for mode_in=1).
//
// Ports:
//   log_clk, log_rst         clock, synchronous active-high reset
//   start_in, abort_in       run control pulses
//   pkt_num_in, size_in,     run parameters, captured on start_in
//   base_addr_in, mode_in
//   nwr_ready_in             core can accept the next packet header
//   nwr_done_in              core finished the current packet
//   user_tready_in           stream backpressure
//   user_addr_o, user_tsize_o          current packet address / size-1
//   user_tdata_o, user_tvalid_o,       payload stream
//   user_tkeep_o, user_tlast_o
//   busy_o, pkt_cnt_o, done_o          run status
// -----------------------------------------------------------------------------
module user_nwr_gen
    import srio_user_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                log_clk,
    input  logic                log_rst,
    input  logic                start_in,
    input  logic                abort_in,
    input  logic [CNT_W-1:0]    pkt_num_in,
    input  logic [11:0]         size_in,
    input  logic [33:0]         base_addr_in,
    input  logic                mode_in,
    input  logic                nwr_ready_in,
    input  logic                nwr_done_in,
    input  logic                user_tready_in,
    output logic [33:0]         user_addr_o,
    output logic [11:0]         user_tsize_o,
    output logic [DATA_W-1:0]   user_tdata_o,
    output logic                user_tvalid_o,
    output logic [DATA_W/8-1:0] user_tkeep_o,
    output logic                user_tlast_o,
    output logic                busy_o,
    output logic [CNT_W-1:0]    pkt_cnt_o,
    output logic                done_o
);

    localparam int BPB      = DATA_W / 8;
    localparam int BPB_LOG2 = $clog2(BPB);

    state_t state, state_nxt;

    logic [CNT_W-1:0]  pkt_num_r;
    logic              mode_r;
    logic [12:0]       beats_r;
    logic [12:0]       beat_cnt;
    logic              abort_pend;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W:0]    pkt_cnt_inc;
    logic              done_r;

    logic              accept;
    logic              last_beat;
    logic              last_accept;
    logic              start_ok;
    logic              done_evt;
    logic              abort_now;
    logic              more_pkts;
    logic [4:0]        rem;
    logic [BPB-1:0]    keep_last;
    logic [DATA_W-1:0] pat_data;

    assign accept      = user_tvalid_o & user_tready_in;
    assign last_beat   = (beat_cnt == beats_r - 13'd1);
    assign last_accept = accept & last_beat;
    assign start_ok    = (state == IDLE) & start_in;
    assign done_evt    = (state == WAIT_DONE) & nwr_done_in;
    // An abort arriving together with nwr_done_in still ends the run.
    assign abort_now   = abort_pend | abort_in;
    assign pkt_cnt_inc = {1'b0, pkt_cnt} + {{CNT_W{1'b0}}, 1'b1};
    // pkt_cnt_inc is the count after the packet just completed.
    assign more_pkts   = (pkt_num_r == '0) || (pkt_cnt_inc < {1'b0, pkt_num_r});

    assign rem       = rem_bytes(user_tsize_o, BPB_LOG2);
    assign keep_last = {BPB{1'b1}} << (BPB - int'(rem));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start_in)     state_nxt = WAIT_RDY;
            WAIT_RDY:  if (nwr_ready_in) state_nxt = DATA;
            DATA:      if (last_accept)  state_nxt = WAIT_DONE;
            WAIT_DONE: if (nwr_done_in)  state_nxt = (more_pkts && !abort_now) ? WAIT_RDY : IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            pkt_num_r    <= '0;
            mode_r       <= 1'b0;
            beats_r      <= '0;
            beat_cnt     <= '0;
            abort_pend   <= 1'b0;
            pkt_cnt      <= '0;
            done_r       <= 1'b0;
            user_addr_o  <= '0;
            user_tsize_o <= '0;
        end else begin
            done_r <= 1'b0;
            if (start_ok) begin
                pkt_num_r    <= pkt_num_in;
                mode_r       <= mode_in;
                beats_r      <= calc_beats(size_in, BPB_LOG2);
                beat_cnt     <= '0;
                abort_pend   <= 1'b0;
                pkt_cnt      <= '0;
                user_addr_o  <= base_addr_in;
                user_tsize_o <= size_in;
            end else begin
                if (abort_in && state != IDLE) begin
                    abort_pend <= 1'b1;
                end
                if (accept) begin
                    beat_cnt <= last_beat ? '0 : beat_cnt + 13'd1;
                end
                // Address moves to the next packet only once this packet's
                // last beat is gone, so it is stable across the whole packet.
                if (last_accept) begin
                    user_addr_o <= user_addr_o + {22'd0, user_tsize_o} + 34'd1;
                end
                if (done_evt) begin
                    pkt_cnt <= pkt_cnt_inc[CNT_W-1:0];
                    if (!(more_pkts && !abort_now)) begin
                        done_r <= 1'b1;
                    end
                end
            end
        end
    end

    user_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .clk     (log_clk),
        .rst     (log_rst),
        .init    (start_ok),
        .advance (accept),
        .mode    (mode_r),
        .data    (pat_data)
    );

    // ------------------------------------------------------------ outputs
    // tvalid follows the DATA state directly: DATA is only left on an
    // accepted last beat, so valid can never drop without acceptance.
    assign user_tvalid_o = (state == DATA);
    assign user_tlast_o  = user_tvalid_o & last_beat;
    assign user_tkeep_o  = !user_tvalid_o ? '0 : (last_beat ? keep_last : '1);
    assign user_tdata_o  = user_tvalid_o ? pat_data : '0;
    assign busy_o        = (state != IDLE);
    assign pkt_cnt_o     = pkt_cnt;
    assign done_o        = done_r;

endmodule

// File: tb/tb_user_nwr_gen.sv
// -----------------------------------------------------------------------------
// tb_user_nwr_gen
// Scoreboard bench for user_nwr_gen (DATA_W=64). Each run pushes the expected
// beats and packet addresses; a negedge monitor pops and compares them on
// every accepted beat and checks that stalled beats hold steady.
// -----------------------------------------------------------------------------
module tb_user_nwr_gen;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;
    localparam int BPB    = DATA_W / 8;
    localparam int LIMIT  = 20000;

`ifdef USER_NWR_GEN_LFSR_EN
    localparam logic IGNORED_MODE = 1'b0;
`else
    localparam logic IGNORED_MODE = 1'b1;
`endif

    logic              log_clk = 1'b0;
    logic              log_rst = 1'b1;
    logic              start_in = 1'b0;
    logic              abort_in = 1'b0;
    logic [CNT_W-1:0]  pkt_num_in = '0;
    logic [11:0]       size_in = '0;
    logic [33:0]       base_addr_in = '0;
    logic              mode_in = 1'b0;
    logic              nwr_ready_in = 1'b1;
    logic              nwr_done_in;
    logic              user_tready_in;
    logic [33:0]       user_addr_o;
    logic [11:0]       user_tsize_o;
    logic [DATA_W-1:0] user_tdata_o;
    logic              user_tvalid_o;
    logic [BPB-1:0]    user_tkeep_o;
    logic              user_tlast_o;
    logic              busy_o;
    logic [CNT_W-1:0]  pkt_cnt_o;
    logic              done_o;

    user_nwr_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .log_clk        (log_clk),
        .log_rst        (log_rst),
        .start_in       (start_in),
        .abort_in       (abort_in),
        .pkt_num_in     (pkt_num_in),
        .size_in        (size_in),
        .base_addr_in   (base_addr_in),
        .mode_in        (mode_in),
        .nwr_ready_in   (nwr_ready_in),
        .nwr_done_in    (nwr_done_in),
        .user_tready_in (user_tready_in),
        .user_addr_o    (user_addr_o),
        .user_tsize_o   (user_tsize_o),
        .user_tdata_o   (user_tdata_o),
        .user_tvalid_o  (user_tvalid_o),
        .user_tkeep_o   (user_tkeep_o),
        .user_tlast_o   (user_tlast_o),
        .busy_o         (busy_o),
        .pkt_cnt_o      (pkt_cnt_o),
        .done_o         (done_o)
    );

    always #5 log_clk = ~log_clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [BPB-1:0]    keep;
        logic              last;
    } beat_t;

    beat_t       exp_q[$];
    logic [33:0] addr_q[$];
    logic [11:0] exp_size = '0;

    int checks      = 0;
    int failures    = 0;
    int beats_seen  = 0;
    int pkts_seen   = 0;
    int beat_in_pkt = 0;
    int done_cnt    = 0;
    bit tready_toggle = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------ ready / done responders
    initial begin
        user_tready_in = 1'b1;
        forever begin
            @(posedge log_clk);
            #1 user_tready_in = tready_toggle ? ~user_tready_in : 1'b1;
        end
    end

    initial begin
        nwr_done_in = 1'b0;
        forever begin
            @(negedge log_clk);
            if (!log_rst && user_tvalid_o && user_tready_in && user_tlast_o) begin
                repeat (3) @(posedge log_clk);
                #1 nwr_done_in = 1'b1;
                @(posedge log_clk);
                #1 nwr_done_in = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------- monitor
    beat_t             mon_e;
    logic [33:0]       mon_a;
    bit                first_beat = 1'b1;
    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [BPB-1:0]    prev_keep;
    logic              prev_last;

    always @(negedge log_clk) begin
        if (log_rst) begin
            first_beat  = 1'b1;
            prev_stall  = 1'b0;
            beat_in_pkt = 0;
        end else begin
            if (user_tlast_o) check("last_needs_valid", user_tvalid_o, 1'b1);
            if (prev_stall) begin
                check("stall_valid", user_tvalid_o, 1'b1);
                check("stall_data", user_tdata_o, prev_data);
                check("stall_keep", user_tkeep_o, prev_keep);
                check("stall_last", user_tlast_o, prev_last);
            end
            if (user_tvalid_o && user_tready_in) begin
                if (first_beat) begin
                    check("addr_q_nonempty", addr_q.size() > 0, 1'b1);
                    if (addr_q.size() > 0) begin
                        mon_a = addr_q.pop_front();
                        check("pkt_addr", user_addr_o, mon_a);
                    end
                    check("pkt_tsize", user_tsize_o, exp_size);
                end
                check("beat_q_nonempty", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", user_tdata_o, mon_e.data);
                    check("beat_keep", user_tkeep_o, mon_e.keep);
                    check("beat_last", user_tlast_o, mon_e.last);
                end
                beats_seen++;
                beat_in_pkt++;
                first_beat = user_tlast_o;
                if (user_tlast_o) begin
                    pkts_seen++;
                    beat_in_pkt = 0;
                end
            end
            prev_stall = user_tvalid_o && !user_tready_in;
            prev_data  = user_tdata_o;
            prev_keep  = user_tkeep_o;
            prev_last  = user_tlast_o;
            if (done_o) done_cnt++;
        end
    end

    // --------------------------------------------------------------- model
    // Counter pattern restarts at 0 on each start and runs across packets.
    task automatic push_run(input int npkts, input logic [11:0] size, input logic [33:0] base);
        logic [31:0] ctr;
        logic [33:0] a;
        logic [BPB-1:0] kl;
        int nb;
        int r;
        beat_t x;
        ctr = 32'd0;
        a   = base;
        nb  = int'(size) / BPB + 1;
        r   = int'(size) % BPB + 1;
        kl  = {BPB{1'b1}} << (BPB - r);
        for (int p = 0; p < npkts; p++) begin
            addr_q.push_back(a);
            a = a + 34'(size) + 34'd1;
            for (int b = 0; b < nb; b++) begin
                x.data = {ctr, ctr + 32'd1};
                ctr    = ctr + 32'd2;
                x.last = (b == nb - 1);
                x.keep = x.last ? kl : {BPB{1'b1}};
                exp_q.push_back(x);
            end
        end
    endtask

    // ----------------------------------------------------------------- run
    task automatic run(input string tag, input logic [CNT_W-1:0] num, input logic [11:0] size,
                       input logic [33:0] base, input logic mode, input int model_pkts,
                       input bit do_abort);
        int d0, p0, b0, t;
        push_run(model_pkts, size, base);
        exp_size = size;
        d0 = done_cnt;
        p0 = pkts_seen;
        b0 = beats_seen;
        @(posedge log_clk);
        #1;
        pkt_num_in   = num;
        size_in      = size;
        base_addr_in = base;
        mode_in      = mode;
        start_in     = 1'b1;
        @(posedge log_clk);
        #1;
        start_in     = 1'b0;
        // Changes after start, and a second start while busy, must be ignored.
        pkt_num_in   = 16'($urandom_range(7, 1));
        size_in      = 12'($urandom);
        base_addr_in = 34'($urandom);
        mode_in      = ~mode;
        @(posedge log_clk);
        #1 start_in = 1'b1;
        @(posedge log_clk);
        #1 start_in = 1'b0;
        if (do_abort) begin
            t = 0;
            while (!((pkts_seen - p0) == 1 && beat_in_pkt >= 1) && t < LIMIT) begin
                @(posedge log_clk);
                t++;
            end
            check({tag, "_abort_window"}, t < LIMIT, 1'b1);
            #1 abort_in = 1'b1;
            @(posedge log_clk);
            #1 abort_in = 1'b0;
        end
        t = 0;
        while (done_cnt == d0 && t < LIMIT) begin
            @(posedge log_clk);
            t++;
        end
        check({tag, "_done_seen"}, done_cnt != d0, 1'b1);
        repeat (4) @(posedge log_clk);
        #1;
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_pkt_cnt"}, pkt_cnt_o, model_pkts);
        check({tag, "_pkts"}, pkts_seen - p0, model_pkts);
        check({tag, "_beats"}, beats_seen - b0, model_pkts * (int'(size) / BPB + 1));
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_sb_empty"}, exp_q.size() + addr_q.size(), 0);
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        int d0, t;
        repeat (3) @(posedge log_clk);
        #1;
        check("rst_tvalid", user_tvalid_o, 1'b0);
        check("rst_tlast", user_tlast_o, 1'b0);
        check("rst_tkeep", user_tkeep_o, '0);
        check("rst_tdata", user_tdata_o, '0);
        check("rst_addr", user_addr_o, '0);
        check("rst_tsize", user_tsize_o, '0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_pkt_cnt", pkt_cnt_o, '0);
        check("rst_done", done_o, 1'b0);
        log_rst = 1'b0;

        run("t1_128B", 16'd1, 12'd127, 34'h0_0000_1000, 1'b0, 1, 1'b0);
        run("t2_5B", 16'd1, 12'd4, 34'h0_0000_2000, IGNORED_MODE, 1, 1'b0);

        tready_toggle = 1'b1;
        run("t3_stall", 16'd1, 12'd255, 34'h0_0000_0000, 1'b0, 1, 1'b0);
        tready_toggle = 1'b0;

        run("t4_wrap", 16'd3, 12'd127, 34'h3_FFFF_FF80, 1'b0, 3, 1'b0);
        run("t5_abort", 16'd0, 12'd63, 34'h3_FFFF_FFC0, 1'b0, 2, 1'b1);

        // Reset in the middle of a packet.
        push_run(1, 12'd255, 34'h0_0000_0100);
        exp_size = 12'd255;
        d0 = done_cnt;
        @(posedge log_clk);
        #1;
        pkt_num_in   = 16'd1;
        size_in      = 12'd255;
        base_addr_in = 34'h0_0000_0100;
        mode_in      = 1'b0;
        start_in     = 1'b1;
        @(posedge log_clk);
        #1 start_in = 1'b0;
        t = 0;
        while (beat_in_pkt < 3 && t < LIMIT) begin
            @(posedge log_clk);
            t++;
        end
        check("mid_rst_window", t < LIMIT, 1'b1);
        #1 log_rst = 1'b1;
        @(posedge log_clk);
        #1;
        check("mid_rst_tvalid", user_tvalid_o, 1'b0);
        check("mid_rst_tlast", user_tlast_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_pkt_cnt", pkt_cnt_o, '0);
        check("mid_rst_addr", user_addr_o, '0);
        log_rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        repeat (6) @(posedge log_clk);
        #1;
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_idle_valid", user_tvalid_o, 1'b0);

        // abort while idle has no effect on the next run.
        abort_in = 1'b1;
        @(posedge log_clk);
        #1 abort_in = 1'b0;

        run("t6_after_rst", 16'd2, 12'd20, 34'h1_2345_6789, 1'b0, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
